// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
package serial_adder_pkg;

    // Legal operand width range
    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 32;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter width: must hold 0..WIDTH and never be narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder used as the serial bit slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and majority carry
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one bit per cycle, LSB first, result valid with a done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned   CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             sub_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             b_bit;
    logic             fa_sum;
    logic             fa_cout;

    // Subtraction uses the inverted B operand with the carry preloaded to 1
    assign b_bit = b_sr[0] ^ sub_q;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_bit),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New result bit enters at the MSB so the LSB ends up in bit 0 after WIDTH shifts
    assign res_next = (res_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    // Controller and serial datapath; outputs change only on state transitions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            sub_q  <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        sub_q  <= sub;
                        carry  <= sub;
                        res_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= fa_cout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= fa_cout;
                        ovf   <= carry ^ fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed WIDTH=8 vectors plus WIDTH=1/32 sweeps.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       rst, start, sub, busy, done, cout, ovf;
    logic [7:0] a, b, sum;

    // Sweep instances share their own reset
    logic        rst_sw;
    logic        start1, sub1, busy1, done1, cout1, ovf1;
    logic [0:0]  a1, b1, sum1;
    logic        start32, sub32, busy32, done32, cout32, ovf32;
    logic [31:0] a32, b32, sum32;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst_sw), .start(start1), .a(a1), .b(b1), .sub(sub1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst_sw), .start(start32), .a(a32), .b(b32), .sub(sub32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  sum;
        logic        cout;
        logic        ovf;
        int unsigned dcyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result and cycle
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_and_done", 64'(busy & done), 64'd0);
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got sum=0x%0h with no pending operation", sum);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("sum",     64'(sum),  64'(mon_e.sum));
                    chk("cout",    64'(cout), 64'(mon_e.cout));
                    chk("ovf",     64'(ovf),  64'(mon_e.ovf));
                    chk("latency", 64'(cyc),  64'(mon_e.dcyc));
                end
            end
        end
    end

    // Issue one WIDTH=8 operation and queue its hand-computed result
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                          input logic [7:0] es, input logic ec, input logic eo,
                          input string tag);
        @(negedge clk);
        a = ta; b = tb; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        sbq.push_back('{es, ec, eo, cyc + 8});
        repeat (12) @(negedge clk);
        chk({tag, "_hold"}, 64'(sum), 64'(es));
    endtask

    task automatic main_seq();
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_wrap");
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_ovf_pos");
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "add_ovf_neg");
        run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_borrow");
        run_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0, "sub_noborrow");
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf");
        run_op(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "sub_zero");

        // Second start three cycles into RUN must be ignored
        @(negedge clk);
        a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sbq.push_back('{8'h46, 1'b0, 1'b0, cyc + 8});
        repeat (2) @(negedge clk);
        a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("busy_start_hold", 64'(sum), 64'h46);

        // Reset four cycles into RUN aborts with no done pulse
        @(negedge clk);
        a = 8'h09; b = 8'h03; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum",  64'(sum),  64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        chk("abort_ovf",  64'(ovf),  64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_idle_busy", 64'(busy), 64'd0);
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "post_reset");
    endtask

    // WIDTH=32 random sweep against an arithmetic reference
    task automatic sweep32();
        logic [31:0] ta, tb, bp;
        logic        ts;
        logic [32:0] r;
        int unsigned n;
        bit          got;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            ta = $urandom; tb = $urandom; ts = 1'($urandom);
            a32 = ta; b32 = tb; sub32 = ts; start32 = 1'b1;
            @(negedge clk);
            start32 = 1'b0;
            n = cyc;
            a32 = $urandom; b32 = $urandom;
            bp = ts ? ~tb : tb;
            r = {1'b0, ta} + {1'b0, bp} + 33'(ts);
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                if (done32) got = 1'b1;
            end
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL w32_timeout: no done within 40 cycles, vector %0d", i);
            end else begin
                chk("w32_latency", 64'(cyc - n), 64'd32);
                chk("w32_sum",  64'(sum32),  64'(r[31:0]));
                chk("w32_cout", 64'(cout32), 64'(r[32]));
                chk("w32_ovf",  64'(ovf32),  64'((ta[31] == bp[31]) && (r[31] != ta[31])));
            end
        end
    endtask

    // WIDTH=1 random sweep against an arithmetic reference
    task automatic sweep1();
        logic        ta, tb, bp, ts;
        logic [1:0]  r;
        int unsigned n;
        bit          got;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            ta = 1'($urandom); tb = 1'($urandom); ts = 1'($urandom);
            a1 = ta; b1 = tb; sub1 = ts; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            n = cyc;
            a1 = 1'($urandom); b1 = 1'($urandom);
            bp = ts ? ~tb : tb;
            r = {1'b0, ta} + {1'b0, bp} + 2'(ts);
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                @(negedge clk);
                if (done1) got = 1'b1;
            end
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL w1_timeout: no done within 8 cycles, vector %0d", i);
            end else begin
                chk("w1_latency", 64'(cyc - n), 64'd1);
                chk("w1_sum",  64'(sum1),  64'(r[0]));
                chk("w1_cout", 64'(cout1), 64'(r[1]));
                chk("w1_ovf",  64'(ovf1),  64'((ta == bp) && (r[0] != ta)));
            end
        end
    endtask

    initial begin
        rst = 1'b1; rst_sw = 1'b1;
        start = 1'b0; a = '0; b = '0; sub = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0;
        start32 = 1'b0; a32 = '0; b32 = '0; sub32 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_sum",  64'(sum),  64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        chk("reset_ovf",  64'(ovf),  64'd0);
        #2 rst = 1'b0; rst_sw = 1'b0;
        fork
            main_seq();
            sweep32();
            sweep1();
        join
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits, legal range 1..32.
REQ-002 Port: clk  in  1  system clock; all state changes on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous and active-high.
REQ-004 Port: start  in  1  request to begin an operation; sampled only in IDLE.
REQ-005 Port: a  in  WIDTH  operand A, captured when start is accepted.
REQ-006 Port: b  in  WIDTH  operand B, captured when start is accepted.
REQ-007 Port: sub  in  1  mode, captured with operands: 0 = A+B, 1 = A-B.
REQ-008 Port: busy  out  1  high while an operation is in progress (RUN state).
REQ-009 Port: done  out  1  one-cycle pulse when the result becomes valid.
REQ-010 Port: sum  out  WIDTH  result; held stable from done until the next accepted start.
REQ-011 Port: cout  out  1  final carry: carry-out in add mode, not-borrow in sub mode.
REQ-012 Port: ovf  out  1  signed two's-complement overflow of the result.

Function
REQ-013 States: IDLE, RUN, DONE; encoding is internal.
REQ-014 IDLE -> RUN on any rising edge with start=1; a, b and sub are latched on that edge, and the bit counter is cleared.
REQ-015 RUN: one bit is processed per cycle, LSB first; bit i = a[i] ^ b'[i] ^ c, where b' = sub ? ~b : b; the carry register is updated to the majority of (a[i], b'[i], c).
REQ-016 The carry register is loaded with sub (0 for add, 1 for subtract) when start is accepted.
REQ-017 RUN -> DONE on the edge that processes bit WIDTH-1, exactly WIDTH edges after acceptance.
REQ-018 DONE lasts one cycle, with done=1; DONE -> IDLE unconditionally on the next edge.
REQ-019 Latency: done is high during the cycle after the (WIDTH)th edge after the start edge; throughput is one operation per WIDTH+2 cycles.
REQ-020 sum, cout and ovf update only on the RUN -> DONE edge; between done pulses they hold their previous values.
REQ-021 ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-022 start is ignored in RUN and DONE; no queuing. Operands changing during RUN have no effect.
REQ-023 busy=1 exactly in RUN; done=1 exactly in DONE; busy and done are never both high.
REQ-024 WIDTH=1: RUN lasts one cycle; the bit counter is at least one bit wide.

Reset
REQ-025 rst=1 forces IDLE immediately, independent of clk.
REQ-026 Reset values: busy=0, done=0, sum=0, cout=0, ovf=0; carry register, bit counter and operand registers are 0.
REQ-027 Reset asserted mid-RUN aborts the operation with no done pulse; sum, cout and ovf return to 0.
REQ-028 After rst deasserts, the first edge with start=1 is accepted normally.

Structure
REQ-029 A shared package serial_adder_pkg holds the state encoding constants and the WIDTH range limits.
REQ-030 One combinational sub-module, full_adder (a, b, cin -> sum, cout), is instantiated once for the bit slice; it is the successor of the existing one-bit adder.
REQ-031 Datapath elements: the operand shift registers, the result shift register, the carry flop and a $clog2(WIDTH+1)-bit counter; no WIDTH-wide adder is permitted.

Verification (WIDTH=8 unless stated)
REQ-032 Add with wrap: a=0xFF, b=0x01, sub=0 -> done 8 cycles after the start edge; sum=0x00, cout=1, ovf=0.
REQ-033 Signed overflow: a=0x7F, b=0x01, sub=0 -> sum=0x80, cout=0, ovf=1. Also a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-034 Subtract with borrow: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0. Also a=0x07, b=0x05 -> sum=0x02, cout=1.
REQ-035 Start while busy: a second start with different operands 3 cycles into RUN is ignored; the result is that of the first operation, and only one done pulse occurs.
REQ-036 Reset mid-operation: rst pulsed 4 cycles into RUN -> busy=0 immediately, no done pulse, sum=0. A following operation 0x12+0x34 -> sum=0x46.
REQ-037 Parameter sweep with WIDTH=1 and WIDTH=32 against a random reference model (1000 vectors each); done latency equals WIDTH in every case.
